input_conditioner: RTL and testbench



---
 rtl/input_pkg.sv | 24 ++
 rtl/input_conditioner_debounce_ch.sv | 104 ++++++++++
 rtl/input_conditioner.sv | 85 ++++++++
 tb/tb_input_conditioner.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
//   Shared definitions for the push-button input conditioner.
//   - ch_e                    : channel index used to address the per-channel
//                               vectors in the top level (C, S, V).
//   - N_CH                    : number of conditioned channels.
//   - DEBOUNCE_CYCLES_DEFAULT : default debounce qualification length, in
//                               synchronised clock cycles.
// -----------------------------------------------------------------------------
package input_pkg;

  // Channel index; the numeric values are the bit positions in the
  // per-channel vectors of the top level.
  typedef enum logic [1:0] {
    CH_C = 2'd0,
    CH_S = 2'd1,
    CH_V = 2'd2
  } ch_e;

  localparam int N_CH = 3;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage : input_pkg

// File: rtl/input_conditioner_debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//   One push-button channel: 2-flop synchroniser, consecutive-cycle debounce
//   filter and press-edge (0->1) pulse generator.
//
//   Parameters
//     DEBOUNCE_CYCLES : consecutive synchronised cycles of disagreement with
//                       the current level needed before a change is accepted
//                       (2..65535).
//
//   Ports
//     clk   in  1  system clock, rising edge
//     rst   in  1  synchronous active-high reset
//     raw   in  1  raw asynchronous button input
//     level out 1  debounced level (registered)
//     press out 1  one-cycle pulse when level is accepted 0->1 (registered)
// -----------------------------------------------------------------------------
module debounce_ch
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits suffice.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject an out-of-range debounce length at elaboration time.
  generate
    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_param
      $error("debounce_ch: DEBOUNCE_CYCLES must be in 2..65535");
    end
  endgenerate

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pulse_r;

  logic             disagree_s;
  logic             at_limit_s;
  logic             stable_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             pulse_nxt_s;

  assign disagree_s = (sync2_r != stable_r);
  assign at_limit_s = (cnt_r == CNT_LAST);

  // Two-flop synchroniser; only sync2_r is used by the filter below.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state: any agreeing cycle restarts the count; the level
  // flips only on the cycle that completes a full disagreeing run.
  always_comb begin
    stable_nxt_s = stable_r;
    cnt_nxt_s    = CNT_ZERO;
    pulse_nxt_s  = 1'b0;
    if (!disagree_s) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (at_limit_s) begin
      stable_nxt_s = sync2_r;
      cnt_nxt_s    = CNT_ZERO;
      // Pulse only for a rising acceptance, registered alongside the level
      // so both become visible in the same cycle.
      pulse_nxt_s  = sync2_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state and press pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
      pulse_r  <= 1'b0;
    end else begin
      stable_r <= stable_nxt_s;
      cnt_r    <= cnt_nxt_s;
      pulse_r  <= pulse_nxt_s;
    end
  end

  assign level = stable_r;
  assign press = pulse_r;

endmodule : debounce_ch

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Front end for the controller state machine: conditions three raw,
//   bouncing push-buttons into debounced levels and one-cycle press pulses.
//   The three channels are identical and fully independent.
//
//   Parameters
//     DEBOUNCE_CYCLES : debounce qualification length (2..65535)
//
//   Ports
//     clk    in  1  system clock, rising edge
//     rst    in  1  synchronous active-high reset
//     C_RAW  in  1  raw coin button (asynchronous)
//     S_RAW  in  1  raw select button (asynchronous)
//     V_RAW  in  1  raw vend/confirm button (asynchronous)
//     C,S,V  out 1  debounced levels (registered)
//     C_P    out 1  one-cycle pulse on accepted 0->1 of C (registered)
//     S_P    out 1  one-cycle pulse on accepted 0->1 of S (registered)
//     V_P    out 1  one-cycle pulse on accepted 0->1 of V (registered)
// -----------------------------------------------------------------------------
module input_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic C_RAW,
  input  logic S_RAW,
  input  logic V_RAW,
  output logic C,
  output logic S,
  output logic V,
  output logic C_P,
  output logic S_P,
  output logic V_P
);

  logic [N_CH-1:0] raw_s;
  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] press_s;

  assign raw_s[CH_C] = C_RAW;
  assign raw_s[CH_S] = S_RAW;
  assign raw_s[CH_V] = V_RAW;

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch_c (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_s[CH_C]),
    .level (level_s[CH_C]),
    .press (press_s[CH_C])
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch_s (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_s[CH_S]),
    .level (level_s[CH_S]),
    .press (press_s[CH_S])
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch_v (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_s[CH_V]),
    .level (level_s[CH_V]),
    .press (press_s[CH_V])
  );

  // Outputs are direct flop outputs of the channel instances.
  assign C   = level_s[CH_C];
  assign S   = level_s[CH_S];
  assign V   = level_s[CH_V];
  assign C_P = press_s[CH_C];
  assign S_P = press_s[CH_S];
  assign V_P = press_s[CH_V];

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//   Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
//   Reference model: a raw value sampled at one edge is seen by the filter
//   two edges later; a level flips when the filter input has disagreed with
//   it on D consecutive edges since the last flip (tracked by the edge number
//   at which the current disagreement began). A press pulse accompanies a
//   0->1 flip.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic C_RAW = 1'b0;
  logic S_RAW = 1'b0;
  logic V_RAW = 1'b0;
  logic C, S, V, C_P, S_P, V_P;

  int errors = 0;
  int checks = 0;

  // model state, index 0=C, 1=S, 2=V
  bit [2:0] m_d1, m_d2, m_st, m_pl;
  int       m_since [3];
  int       n = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .C_RAW (C_RAW),
    .S_RAW (S_RAW),
    .V_RAW (V_RAW),
    .C     (C),
    .S     (S),
    .V     (V),
    .C_P   (C_P),
    .S_P   (S_P),
    .V_P   (V_P)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] dut_vec();
    return {C, S, V, C_P, S_P, V_P};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_st[0], m_st[1], m_st[2], m_pl[0], m_pl[1], m_pl[2]};
  endfunction

  task automatic model_edge();
    bit [2:0] raw;
    raw = {V_RAW, S_RAW, C_RAW};
    if (rst) begin
      m_d1 = 3'b000; m_d2 = 3'b000; m_st = 3'b000; m_pl = 3'b000;
      for (int c = 0; c < 3; c++) m_since[c] = -1;
    end else begin
      for (int c = 0; c < 3; c++) begin
        m_pl[c] = 1'b0;
        if (m_d2[c] == m_st[c]) begin
          m_since[c] = -1;
        end else begin
          if (m_since[c] < 0) m_since[c] = n;
          if (n - m_since[c] + 1 >= D) begin
            m_st[c]    = m_d2[c];
            m_pl[c]    = m_d2[c];
            m_since[c] = -1;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
    n++;
  endtask

  // Advance one clock; the model follows the same edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; C_RAW = 1'b1; S_RAW = 1'b1; V_RAW = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dut_vec() !== 6'b000000) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got=%b want=000000", i, dut_vec());
      end
    end
    C_RAW = 1'b0; S_RAW = 1'b0; V_RAW = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dut_vec() !== 6'b000000) begin
        errors++;
        $display("FAIL idle_after_reset cycle=%0d got=%b want=000000", i, dut_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses;
    pulses = 0;
    C_RAW = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (C_P === 1'b1) pulses++;
      checks++;
      if (dut_vec() !== {(i >= 5), 1'b0, 1'b0, (i == 5), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL clean_press edge=%0d got=%b want=%b", i, dut_vec(),
                 {(i >= 5), 1'b0, 1'b0, (i == 5), 1'b0, 1'b0});
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL clean_press_pulse_count got=%0d want=1", pulses);
    end
    C_RAW = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clean_release edge=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        S_RAW = (k != 3);
        tick();
        checks++;
        if ((S !== 1'b0) || (S_P !== 1'b0) || (dut_vec() !== exp_vec())) begin
          errors++;
          $display("FAIL bounce_no_change rep=%0d step=%0d got=%b want=%b", r, k,
                   dut_vec(), exp_vec());
        end
      end
    end
    S_RAW = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (S_P === 1'b1) pulses++;
      checks++;
      if ((S !== (i >= 5)) || (S_P !== (i == 5)) || (dut_vec() !== exp_vec())) begin
        errors++;
        $display("FAIL bounce_settle edge=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulse_count got=%0d want=1", pulses);
    end
    S_RAW = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_release();
    V_RAW = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (V !== 1'b1) begin
      errors++;
      $display("FAIL release_setup got=%b want=1", V);
    end
    V_RAW = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ((V !== (i < 5)) || (V_P !== 1'b0) || (dut_vec() !== exp_vec())) begin
        errors++;
        $display("FAIL release_fall edge=%0d got V=%b V_P=%b want V=%b V_P=0", i, V, V_P,
                 (i < 5));
      end
    end
    V_RAW = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 13; i++) begin
      V_RAW = !(i < 3);
      tick();
      checks++;
      if ((V !== 1'b1) || (V_P !== 1'b0) || (dut_vec() !== exp_vec())) begin
        errors++;
        $display("FAIL release_glitch edge=%0d got V=%b V_P=%b want V=1 V_P=0", i, V, V_P);
      end
    end
    V_RAW = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_simultaneous();
    int both;
    both = 0;
    C_RAW = 1'b1; V_RAW = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if ((C_P === 1'b1) && (V_P === 1'b1)) both++;
      checks++;
      if ((C_P !== V_P) || (S_P !== 1'b0) || (dut_vec() !== exp_vec())) begin
        errors++;
        $display("FAIL simultaneous edge=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (both != 1) begin
      errors++;
      $display("FAIL simultaneous_joint_pulse got=%0d want=1", both);
    end
    C_RAW = 1'b0; V_RAW = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid();
    C_RAW = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dut_vec() !== 6'b000000) begin
      errors++;
      $display("FAIL reset_mid_clear got=%b want=000000", dut_vec());
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++;
      if ((C !== (j >= 6)) || (C_P !== (j == 6)) || (dut_vec() !== exp_vec())) begin
        errors++;
        $display("FAIL reset_mid_requalify edge=%0d got=%b want=%b", j, dut_vec(), exp_vec());
      end
    end
    // reset landing in the middle of a count
    C_RAW = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    C_RAW = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++;
      if ((C !== (j >= 6)) || (C_P !== (j == 6)) || (dut_vec() !== exp_vec())) begin
        errors++;
        $display("FAIL reset_mid_count edge=%0d got=%b want=%b", j, dut_vec(), exp_vec());
      end
    end
    C_RAW = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_random();
    int hold [3];
    bit [2:0] val;
    for (int c = 0; c < 3; c++) hold[c] = 0;
    val = 3'b000;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          val[c]  = $urandom_range(1, 0);
          hold[c] = ($urandom_range(3, 0) == 0) ? $urandom_range(12, 5) : $urandom_range(4, 1);
        end
        hold[c]--;
      end
      C_RAW = val[0]; S_RAW = val[1]; V_RAW = val[2];
      rst = ($urandom_range(199, 0) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random step=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0; C_RAW = 1'b0; S_RAW = 1'b0; V_RAW = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) m_since[c] = -1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_input_conditioner
